// File: rtl/branch_resolve_unit.sv
// Tracks fetch-time predictions in order and resolves them against execute outcomes,
// driving predictor updates and pipeline flush. Optional perf counters: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic [31:0]   if_pc,
  input  logic          if_hit,
  input  logic          if_pred_taken,
  input  logic [31:0]   if_pred_target,
  input  logic          ex_valid,
  input  logic [31:0]   ex_pc,
  input  logic          ex_is_branch,
  input  logic          ex_taken,
  input  logic [31:0]   ex_target,
  output logic          flush,
  output logic [31:0]   redirect_pc,
  output logic [31:0]   upd_addr,
  output logic [31:0]   upd_pred,
  output logic          upd_state_write,
  output logic          upd_state_change,
  output logic          upd_branch,
  output logic          order_err,
  output logic [AW:0]   count
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]   perf_branches,
  output logic [31:0]   perf_mispred
`endif
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [31:0] pc_mem  [DEPTH];
  logic        hit_mem [DEPTH];
  logic        pt_mem  [DEPTH];
  logic [31:0] tgt_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          flush_q, upd_sw_q, upd_sc_q, upd_br_q, order_err_q;
  logic [31:0]   redirect_q, upd_addr_q, upd_pred_q;

  logic        push, pop_req, pop, order_fault;
  logic        head_hit, head_pt;
  logic [31:0] head_pc, head_tgt;
  logic        act_taken, mispredict;
  logic [31:0] actual_next;

  assign if_ready         = (count_q != FullCount);
  assign count            = count_q;
  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign upd_addr         = upd_addr_q;
  assign upd_pred         = upd_pred_q;
  assign upd_state_write  = upd_sw_q;
  assign upd_state_change = upd_sc_q;
  assign upd_branch       = upd_br_q;
  assign order_err        = order_err_q;

  always_comb begin
    push        = if_valid && if_ready && !flush_q;
    pop_req     = ex_valid && !flush_q;
    pop         = pop_req && (count_q != '0);
    head_pc     = pc_mem[rd_ptr_q];
    head_hit    = hit_mem[rd_ptr_q];
    head_pt     = pt_mem[rd_ptr_q];
    head_tgt    = tgt_mem[rd_ptr_q];
    act_taken   = ex_is_branch && ex_taken;
    actual_next = act_taken ? ex_target : ex_pc + 32'd4;
    mispredict  = (head_pt != act_taken) || (head_pt && (head_tgt != ex_target));
    // Empty pop and out-of-order resolve are both reported as order faults.
    order_fault = pop_req && ((count_q == '0) || (ex_pc != head_pc));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= if_pc;
      hit_mem[wr_ptr_q] <= if_hit;
      pt_mem[wr_ptr_q]  <= if_pred_taken;
      tgt_mem[wr_ptr_q] <= if_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flush_q     <= 1'b0;
      upd_sw_q    <= 1'b0;
      upd_sc_q    <= 1'b0;
      upd_br_q    <= 1'b0;
      order_err_q <= 1'b0;
      redirect_q  <= '0;
      upd_addr_q  <= '0;
      upd_pred_q  <= '0;
    end else if (flush_q) begin
      // Flush cycle: discard everything, ignore fetch and execute.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flush_q  <= 1'b0;
      upd_sw_q <= 1'b0;
      upd_sc_q <= 1'b0;
      upd_br_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      flush_q  <= pop && mispredict;
      upd_sw_q <= pop && ex_is_branch && head_hit;
      upd_sc_q <= pop && ex_taken;
      upd_br_q <= pop && act_taken;
      if (pop) begin
        redirect_q <= actual_next;
        upd_addr_q <= ex_pc;
        upd_pred_q <= actual_next;
      end
      if (order_fault) order_err_q <= 1'b1;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mp_q;

  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (pop && ex_is_branch && (perf_br_q != 32'hFFFF_FFFF)) perf_br_q <= perf_br_q + 32'd1;
      if (pop && mispredict && (perf_mp_q != 32'hFFFF_FFFF))   perf_mp_q <= perf_mp_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized check of branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready, if_hit, if_pred_taken;
  logic [31:0] if_pc, if_pred_target;
  logic        ex_valid, ex_is_branch, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        flush, upd_state_write, upd_state_change, upd_branch, order_err;
  logic [31:0] redirect_pc, upd_addr, upd_pred;
  logic [AW:0] count;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispred;
`endif

  branch_resolve_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_hit(if_hit),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_target(ex_target),
    .flush(flush), .redirect_pc(redirect_pc), .upd_addr(upd_addr), .upd_pred(upd_pred),
    .upd_state_write(upd_state_write), .upd_state_change(upd_state_change),
    .upd_branch(upd_branch), .order_err(order_err), .count(count)
`ifdef BRU_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_mispred(perf_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        pt;
    logic [31:0] tgt;
  } entry_t;

  entry_t      q[$];
  logic        m_flush, m_sw, m_sc, m_br, m_err;
  logic [31:0] m_redir, m_addr, m_pred, m_pb, m_pm;
  int          checks = 0;
  int          failures = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 0; m_sw = 0; m_sc = 0; m_br = 0; m_err = 0;
    m_redir = 0; m_addr = 0; m_pred = 0; m_pb = 0; m_pm = 0;
  endtask

  // Advance one clock: update the model from current inputs, then compare all outputs.
  task automatic step();
    entry_t      h;
    entry_t      e;
    logic        real_taken, mis, room;
    logic [31:0] nxt;
    if (rst) begin
      model_reset();
    end else if (m_flush) begin
      q.delete();
      m_flush = 0; m_sw = 0; m_sc = 0; m_br = 0;
    end else begin
      room = (q.size() < DEPTH);
      m_flush = 0; m_sw = 0; m_sc = 0; m_br = 0;
      if (ex_valid) begin
        if (q.size() == 0) begin
          m_err = 1;
        end else begin
          h = q.pop_front();
          if (h.pc != ex_pc) m_err = 1;
          real_taken = ex_is_branch && ex_taken;
          nxt = real_taken ? ex_target : ex_pc + 32'd4;
          mis = (h.pt != real_taken) || (h.pt && h.tgt != ex_target);
          m_flush = mis;
          m_redir = nxt;
          m_addr  = ex_pc;
          m_pred  = nxt;
          m_br    = real_taken;
          m_sw    = ex_is_branch && h.hit;
          m_sc    = ex_taken;
          if (ex_is_branch && m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
          if (mis && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
        end
      end
      if (if_valid && room) begin
        e.pc = if_pc; e.hit = if_hit; e.pt = if_pred_taken; e.tgt = if_pred_target;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk32("count", 32'(count), 32'(q.size()));
    chk1("if_ready", if_ready, q.size() < DEPTH);
    chk1("flush", flush, m_flush);
    chk32("redirect_pc", redirect_pc, m_redir);
    chk32("upd_addr", upd_addr, m_addr);
    chk32("upd_pred", upd_pred, m_pred);
    chk1("upd_state_write", upd_state_write, m_sw);
    chk1("upd_state_change", upd_state_change, m_sc);
    chk1("upd_branch", upd_branch, m_br);
    chk1("order_err", order_err, m_err);
`ifdef BRU_PERF_CNT_EN
    chk32("perf_branches", perf_branches, m_pb);
    chk32("perf_mispred", perf_mispred, m_pm);
`endif
  endtask

  task automatic idle();
    rst = 0; if_valid = 0; ex_valid = 0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic hit, input logic pt,
                          input logic [31:0] tgt);
    if_valid = 1; if_pc = pc; if_hit = hit; if_pred_taken = pt; if_pred_target = tgt;
  endtask

  task automatic set_pop(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt);
    ex_valid = 1; ex_pc = pc; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
  endtask

  initial begin
    model_reset();
    rst = 1; if_valid = 0; ex_valid = 0; if_pc = 0; if_hit = 0; if_pred_taken = 0;
    if_pred_target = 0; ex_pc = 0; ex_is_branch = 0; ex_taken = 0; ex_target = 0;
    step();
    chk32("reset_count", 32'(count), 32'd0);
    chk1("reset_ready", if_ready, 1'b1);

    // Correct taken prediction
    idle(); set_push(32'h100, 1, 1, 32'h200); step();
    idle(); set_pop(32'h100, 1, 1, 32'h200); step();
    chk1("t1_flush", flush, 1'b0);
    chk1("t1_branch", upd_branch, 1'b1);
    chk1("t1_sw", upd_state_write, 1'b1);
    chk1("t1_sc", upd_state_change, 1'b1);
    chk32("t1_addr", upd_addr, 32'h100);
    chk32("t1_pred", upd_pred, 32'h200);
    idle(); step();
    chk1("t1_pulse_end", upd_branch, 1'b0);

    // Direction mispredict
    idle(); set_push(32'h40, 0, 0, 32'h0); step();
    idle(); set_pop(32'h40, 1, 1, 32'h80); step();
    chk1("t2_flush", flush, 1'b1);
    chk32("t2_redirect", redirect_pc, 32'h80);
    chk1("t2_sw", upd_state_write, 1'b0);
    chk1("t2_branch", upd_branch, 1'b1);
    idle(); step();
    chk32("t2_count", 32'(count), 32'd0);

    // Fill, drop on full, then steady pop/push with wrap
    for (int i = 0; i < 4; i++) begin
      idle(); set_push(32'(i * 4), 0, 0, 32'h0); step();
    end
    chk1("t3_full_ready", if_ready, 1'b0);
    idle(); set_push(32'h10, 0, 0, 32'h0); step();
    chk32("t3_drop_count", 32'(count), 32'd4);
    for (int i = 0; i < 8; i++) begin
      idle(); set_pop(q[0].pc, 0, 0, 32'h0); set_push(32'(16 + i * 4), 0, 0, 32'h0); step();
      chk1("t3_no_err", order_err, 1'b0);
    end
    while (q.size() != 0) begin
      idle(); set_pop(q[0].pc, 0, 0, 32'h0); step();
    end

    // Aliased non-branch predicted taken
    idle(); set_push(32'h20, 1, 1, 32'h300); step();
    idle(); set_push(32'h24, 0, 0, 32'h0); step();
    idle(); set_pop(32'h20, 0, 0, 32'h0); step();
    chk1("t4_flush", flush, 1'b1);
    chk32("t4_redirect", redirect_pc, 32'h24);
    chk1("t4_branch", upd_branch, 1'b0);
    chk1("t4_sw", upd_state_write, 1'b0);

    // Flush priority over push and pop, then empty-pop fault
    idle(); set_push(32'h500, 0, 0, 32'h0); set_pop(32'h24, 0, 0, 32'h0); step();
    chk32("t5_count", 32'(count), 32'd0);
    chk1("t5_no_err", order_err, 1'b0);
    idle(); set_pop(32'h600, 0, 0, 32'h0); step();
    chk1("t5_err_set", order_err, 1'b1);
    idle(); step(); step();
    chk1("t5_err_sticky", order_err, 1'b1);

    // Reset with entries queued
    for (int i = 0; i < 3; i++) begin
      idle(); set_push(32'(32'h700 + i * 4), 1, 1, 32'h900); step();
    end
    idle(); rst = 1; step();
    chk32("t6_count", 32'(count), 32'd0);
    chk1("t6_ready", if_ready, 1'b1);
    chk1("t6_err", order_err, 1'b0);
    chk32("t6_addr", upd_addr, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom % 80 == 0);
      if_valid       = 1'($urandom % 2);
      if_pc          = 32'(($urandom % 64) * 4);
      if_hit         = 1'($urandom % 2);
      if_pred_taken  = if_hit & 1'($urandom % 2);
      if_pred_target = 32'h1000 + 32'(($urandom % 4) * 4);
      ex_valid       = 1'($urandom % 2);
      ex_pc          = 32'(($urandom % 64) * 4);
      if (q.size() != 0 && ($urandom % 16) != 0) ex_pc = q[0].pc;
      ex_is_branch   = 1'($urandom % 2);
      ex_taken       = 1'($urandom % 2);
      ex_target      = 32'h1000 + 32'(($urandom % 4) * 4);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
